cic_decimator_front: RTL and testbench

//   Integrator section and rate-reduction front end of the CIC decimation chain.

---
 rtl/cic_pkg.sv | 18 +
 rtl/cic_integrator.sv | 20 ++
 rtl/cic_decimator_front.sv | 67 ++++++
 tb/tb_cic_decimator_front.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimation chain: accumulator width sizing and
// sign extension used by both the integrator and comb sections.
package cic_pkg;

    // Bit growth of a CIC filter is STAGES*log2(R*M) on top of the input width.
    function automatic int cic_acc_width(input int iw, input int stages,
                                         input int r, input int m);
        return iw + stages * $clog2(r * m);
    endfunction

    // Sign-extend the low w bits of x to 64 bits; callers cast down to their width.
    function automatic logic [63:0] sign_extend(input logic [63:0] x, input int w);
        logic [63:0] hi_mask;
        hi_mask = ~64'd0 << w;
        return x[w-1] ? (x | hi_mask) : (x & ~hi_mask);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: a modulo-2^AW accumulator advanced on i_ce.
module cic_integrator #(
    parameter int AW = 14
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [AW-1:0] i_addend,
    output logic [AW-1:0] o_acc
);

    // Overflow wraps on purpose; the comb section recovers the exact result.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_acc <= '0;
        else if (i_ce)
            o_acc <= o_acc + i_addend;
    end

endmodule

// File: rtl/cic_decimator_front.sv
// CIC decimator front end: STAGES cascaded integrators at the input rate,
// followed by a 1-in-R sample picker that strobes o_ready with o_data.
module cic_decimator_front
    import cic_pkg::*;
#(
    parameter int IW     = 5,
    parameter int STAGES = 3,
    parameter int R      = 8,
    parameter int M      = 1,
    parameter int OW     = 14
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    output logic [OW-1:0] o_data,
    output logic          o_ready
);

    localparam int AW = cic_acc_width(IW, STAGES, R, M);
    localparam int CW = $clog2(R);
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    logic [STAGES-1:0][AW-1:0] acc;
    logic [STAGES-1:0][AW-1:0] stage_in;
    logic [CW-1:0]             cnt;

    // Each stage adds the previous stage's registered value, so the cascade is
    // naturally pipelined by one i_ce per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in[k] = AW'(sign_extend(64'(i_data), IW));
        end else begin : g_next
            assign stage_in[k] = acc[k-1];
        end

        cic_integrator #(.AW(AW)) u_integrator (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_ce     (i_ce),
            .i_addend (stage_in[k]),
            .o_acc    (acc[k])
        );
    end

    // cnt counts i_ce pulses, not clocks; the top OW bits of the last stage
    // are captured on the R-th pulse of each window.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt     <= '0;
            o_data  <= '0;
            o_ready <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            if (i_ce) begin
                if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    o_data  <= acc[STAGES-1][AW-1 -: OW];
                    o_ready <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator_front.sv
// Directed bench for cic_decimator_front: three parameterisations sharing one
// clock and reset, checked against hand-computed values and a small CIC model.
module tb_cic_decimator_front;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_reset;

    // Defaults: IW=5, STAGES=3, R=8, AW=OW=14
    logic        a_ce;
    logic [4:0]  a_din;
    logic [13:0] a_dout;
    logic        a_rdy;

    // STAGES=1, R=4 -> AW=7
    logic        b_ce;
    logic [4:0]  b_din;
    logic [6:0]  b_dout;
    logic        b_rdy;

    // STAGES=1, R=2 -> AW=6
    logic        c_ce;
    logic [4:0]  c_din;
    logic [5:0]  c_dout;
    logic        c_rdy;

    int checks = 0;
    int errors = 0;

    cic_decimator_front dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(a_ce), .i_data(a_din),
        .o_data(a_dout), .o_ready(a_rdy)
    );

    cic_decimator_front #(.IW(5), .STAGES(1), .R(4), .M(1), .OW(7)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(b_ce), .i_data(b_din),
        .o_data(b_dout), .o_ready(b_rdy)
    );

    cic_decimator_front #(.IW(5), .STAGES(1), .R(2), .M(1), .OW(6)) dut_c (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(c_ce), .i_data(c_din),
        .o_data(c_dout), .o_ready(c_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_reset = 1'b1;
        a_ce = 1'b0; b_ce = 1'b0; c_ce = 1'b0;
        a_din = '0;  b_din = '0;  c_din = '0;
        tick;
        tick;
        i_reset = 1'b0;
    endtask

    int          exp_casc [8] = '{35, 455, 1771, 4495, 9139, 16215, 9851, 6943};
    int          exp_wrap [8] = '{15, 45, 11, 41, 7, 37, 3, 33};
    logic [13:0] z1, z2, z3, d1, d2, d3;
    logic [13:0] m0, m1, m2, mdata;
    int          mcnt, k;
    logic        ce_r, exp_rdy;
    logic [4:0]  d_r;

    initial begin
        i_reset = 1'b0;
        a_ce = 1'b0; b_ce = 1'b0; c_ce = 1'b0;
        a_din = '0;  b_din = '0;  c_din = '0;
        #2 i_reset = 1'b1;
        #1;
        chk("rst_a_data", 32'(a_dout), 0);
        chk("rst_a_rdy",  32'(a_rdy),  0);
        chk("rst_b_data", 32'(b_dout), 0);
        chk("rst_b_rdy",  32'(b_rdy),  0);
        chk("rst_c_data", 32'(c_dout), 0);
        chk("rst_c_rdy",  32'(c_rdy),  0);
        tick;
        tick;
        i_reset = 1'b0;

        // Zero input: strobes only on every 8th i_ce, data stays 0
        a_din = '0;
        for (int n = 1; n <= 40; n++) begin
            a_ce = 1'b1;
            tick;
            chk("zero_rdy",  32'(a_rdy),  32'(n % 8 == 0));
            chk("zero_data", 32'(a_dout), 0);
        end
        a_ce = 1'b0;
        tick;
        chk("idle_rdy", 32'(a_rdy), 0);

        // Single-stage impulse: held accumulator shows 1 at every strobe
        do_reset;
        for (int n = 1; n <= 12; n++) begin
            b_ce  = 1'b1;
            b_din = (n == 1) ? 5'd1 : 5'd0;
            tick;
            chk("imp_rdy", 32'(b_rdy), 32'(n % 4 == 0));
            if (n % 4 == 0) chk("imp_data", 32'(b_dout), 1);
        end
        b_ce = 1'b0;

        // Step response through integrators, then a 3-stage comb -> 512
        do_reset;
        a_din = 5'd1;
        a_ce  = 1'b1;
        z1 = '0; z2 = '0; z3 = '0;
        k = 0;
        for (int n = 1; n <= 64; n++) begin
            tick;
            if (n % 8 == 0) begin
                chk("casc_rdy", 32'(a_rdy), 1);
                chk("casc_int", 32'(a_dout), 32'(exp_casc[k]));
                d1 = a_dout - z1; z1 = a_dout;
                d2 = d1 - z2;     z2 = d1;
                d3 = d2 - z3;     z3 = d2;
                k++;
                if (k >= 4) chk("casc_comb", 32'(d3), 512);
            end else begin
                chk("casc_rdy", 32'(a_rdy), 0);
            end
        end
        a_ce = 1'b0;

        // Constant 15 into a 6-bit accumulator: values wrap mod 64
        do_reset;
        c_din = 5'd15;
        for (int n = 1; n <= 16; n++) begin
            c_ce = 1'b1;
            tick;
            chk("wrap_rdy", 32'(c_rdy), 32'(n % 2 == 0));
            if (n % 2 == 0) chk("wrap_data", 32'(c_dout), 32'(exp_wrap[n/2 - 1]));
        end
        c_ce = 1'b0;

        // Gapped i_ce with random signed data against a modulo model
        do_reset;
        m0 = '0; m1 = '0; m2 = '0; mdata = '0; mcnt = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            ce_r  = ($urandom_range(0, 9) < 3);
            d_r   = 5'($urandom_range(0, 31));
            a_ce  = ce_r;
            a_din = d_r;
            tick;
            exp_rdy = 1'b0;
            if (ce_r) begin
                if (mcnt == 7) begin
                    exp_rdy = 1'b1;
                    mdata   = m2;
                    mcnt    = 0;
                end else begin
                    mcnt++;
                end
                m2 = m2 + m1;
                m1 = m1 + m0;
                m0 = m0 + {{9{d_r[4]}}, d_r};
            end
            chk("gap_rdy",  32'(a_rdy),  32'(exp_rdy));
            chk("gap_data", 32'(a_dout), 32'(mdata));
        end
        a_ce = 1'b0;

        // Reset at i_ce #13: immediate clear, restart counts from zero
        do_reset;
        a_din = 5'd1;
        for (int n = 1; n <= 12; n++) begin
            a_ce = 1'b1;
            tick;
            if (n == 8) chk("mid_pre_data", 32'(a_dout), 35);
        end
        a_ce    = 1'b1;
        i_reset = 1'b1;
        #1;
        chk("mid_async_data", 32'(a_dout), 0);
        chk("mid_async_rdy",  32'(a_rdy),  0);
        for (int n = 0; n < 3; n++) begin
            tick;
            chk("mid_hold_data", 32'(a_dout), 0);
            chk("mid_hold_rdy",  32'(a_rdy),  0);
        end
        i_reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            a_ce = 1'b1;
            tick;
            chk("mid_post_rdy",  32'(a_rdy),  32'(n == 8));
            chk("mid_post_data", 32'(a_dout), (n == 8) ? 35 : 0);
        end
        a_ce = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
